// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALU operation codes, writeback selects and MUL FSM states.
package pipe_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_NPC = 2'b10;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

// File: rtl/iter_mul.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle. The start cycle consumes bit 0,
// so BUSY lasts DATA_W-1 cycles before DONE presents the low DATA_W bits of the product.
module iter_mul
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d  = MUL_BUSY;
          prod_d   = b_i[0] ? a_i : '0;
          mcand_d  = a_i << 1;
          mplier_d = b_i >> 1;
          cnt_d    = CntW'(1);
        end
      end
      MUL_BUSY: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (abort_i) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else if (!stall_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = prod_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, optional iterative multiplier (EX_STAGE_MUL_EN) and the EX/MEM register.
// Without EX_STAGE_MUL_EN the MUL opcode behaves as an undefined ALU code and ex_busy is tied 0.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic [3:0]            ALUop,
  input  logic                  ALUSrc,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [DATA_W-1:0]     Imm,
  input  logic [DATA_W-1:0]     NPC2,
  input  logic [REG_ADDR_W-1:0] rd2,
  input  logic                  RegWrite_ID,
  input  logic                  memR_ID,
  input  logic                  memW_ID,
  input  logic [1:0]            WBdata_ID,
  output logic                  RegWrite_EX,
  output logic                  memR,
  output logic                  memW,
  output logic [1:0]            WBdata,
  output logic [DATA_W-1:0]     ALUout,
  output logic [DATA_W-1:0]     D,
  output logic [DATA_W-1:0]     NPC3,
  output logic [REG_ADDR_W-1:0] rd3,
  output logic                  ex_busy
);

  logic [DATA_W-1:0] op2, alu_res, res;
  logic [4:0]        shamt;
  logic              mul_hold;

  logic                  reg_write_q, reg_write_d;
  logic                  mem_r_q, mem_r_d;
  logic                  mem_w_q, mem_w_d;
  logic [1:0]            wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0]     alu_out_q, alu_out_d;
  logic [DATA_W-1:0]     store_data_q, store_data_d;
  logic [DATA_W-1:0]     npc_q, npc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  assign op2   = ALUSrc ? Imm : B;
  assign shamt = op2[4:0];

  always_comb begin
    alu_res = '0;
    case (ALUop)
      ALU_ADD:   alu_res = A + op2;
      ALU_SUB:   alu_res = A - op2;
      ALU_AND:   alu_res = A & op2;
      ALU_OR:    alu_res = A | op2;
      ALU_XOR:   alu_res = A ^ op2;
      ALU_SLL:   alu_res = A << shamt;
      ALU_SRL:   alu_res = A >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(A) >>> shamt);
      ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(op2))};
      ALU_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (A < op2)};
      ALU_PASSB: alu_res = op2;
      default:   alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;

  // Only launch from IDLE so the still-held MUL in DONE cannot restart the multiplier.
  assign mul_start = !reset && valid_in && (ALUop == ALU_MUL) && !flush_in && !stall_in &&
                     !mul_busy && !mul_done;

  iter_mul #(
    .DATA_W(DATA_W)
  ) u_iter_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start),
    .abort_i  (flush_in),
    .stall_i  (stall_in),
    .a_i      (A),
    .b_i      (op2),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  assign mul_hold = mul_start || mul_busy;
  assign ex_busy  = !reset && (mul_start || (mul_busy && !flush_in));
  assign res      = mul_done ? mul_prod : alu_res;
`else
  assign mul_hold = 1'b0;
  assign ex_busy  = 1'b0;
  assign res      = alu_res;
`endif

  always_comb begin
    reg_write_d  = reg_write_q;
    mem_r_d      = mem_r_q;
    mem_w_d      = mem_w_q;
    wb_sel_d     = wb_sel_q;
    alu_out_d    = alu_out_q;
    store_data_d = store_data_q;
    npc_d        = npc_q;
    rd_d         = rd_q;
    if (flush_in || (!stall_in && (!valid_in || mul_hold))) begin
      reg_write_d  = 1'b0;
      mem_r_d      = 1'b0;
      mem_w_d      = 1'b0;
      wb_sel_d     = '0;
      alu_out_d    = '0;
      store_data_d = '0;
      npc_d        = '0;
      rd_d         = '0;
    end else if (!stall_in) begin
      reg_write_d  = RegWrite_ID && (rd2 != '0);
      mem_r_d      = memR_ID;
      mem_w_d      = memW_ID;
      wb_sel_d     = WBdata_ID;
      alu_out_d    = res;
      store_data_d = B;
      npc_d        = NPC2;
      rd_d         = rd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      wb_sel_q     <= '0;
      alu_out_q    <= '0;
      store_data_q <= '0;
      npc_q        <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_r_q      <= mem_r_d;
      mem_w_q      <= mem_w_d;
      wb_sel_q     <= wb_sel_d;
      alu_out_q    <= alu_out_d;
      store_data_q <= store_data_d;
      npc_q        <= npc_d;
      rd_q         <= rd_d;
    end
  end

  assign RegWrite_EX = reg_write_q;
  assign memR        = mem_r_q;
  assign memW        = mem_w_q;
  assign WBdata      = wb_sel_q;
  assign ALUout      = alu_out_q;
  assign D           = store_data_q;
  assign NPC3        = npc_q;
  assign rd3         = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues expected EX/MEM contents and ex_busy values,
// a negedge monitor pops and compares them. MUL cases follow EX_STAGE_MUL_EN.
module tb_ex_stage;
  import pipe_pkg::*;

  bit          clk;
  logic        reset, valid_in, stall_in, flush_in;
  logic [3:0]  ALUop;
  logic        ALUSrc;
  logic [31:0] A, B, Imm, NPC2;
  logic [4:0]  rd2;
  logic        RegWrite_ID, memR_ID, memW_ID;
  logic [1:0]  WBdata_ID;
  logic        RegWrite_EX, memR, memW;
  logic [1:0]  WBdata;
  logic [31:0] ALUout, D, NPC3;
  logic [4:0]  rd3;
  logic        ex_busy;

  ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .ALUop(ALUop), .ALUSrc(ALUSrc), .A(A), .B(B), .Imm(Imm), .NPC2(NPC2), .rd2(rd2),
    .RegWrite_ID(RegWrite_ID), .memR_ID(memR_ID), .memW_ID(memW_ID), .WBdata_ID(WBdata_ID),
    .RegWrite_EX(RegWrite_EX), .memR(memR), .memW(memW), .WBdata(WBdata), .ALUout(ALUout),
    .D(D), .NPC3(NPC3), .rd3(rd3), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    logic        rw, mr, mw;
    logic [1:0]  wb;
    logic [31:0] alu, d, npc;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    int    due;
    string tag;
    logic  busy;
  } bexp_t;

  exp_t  q_out[$];
  bexp_t q_busy[$];
  exp_t  last_exp;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin : monitor
    exp_t  e;
    bexp_t b;
    while (q_out.size() > 0 && q_out[0].due <= cyc) begin
      e = q_out.pop_front();
      n_vec++;
      if (e.due != cyc) begin
        n_err++;
        $display("FAIL %s: check missed, due cycle %0d seen at %0d", e.tag, e.due, cyc);
      end else if ({RegWrite_EX, memR, memW, WBdata, ALUout, D, NPC3, rd3} !==
                   {e.rw, e.mr, e.mw, e.wb, e.alu, e.d, e.npc, e.rd}) begin
        n_err++;
        $display("FAIL %s: got rw=%b mr=%b mw=%b wb=%b alu=%h d=%h npc=%h rd=%0d, expected rw=%b mr=%b mw=%b wb=%b alu=%h d=%h npc=%h rd=%0d",
                 e.tag, RegWrite_EX, memR, memW, WBdata, ALUout, D, NPC3, rd3,
                 e.rw, e.mr, e.mw, e.wb, e.alu, e.d, e.npc, e.rd);
      end
    end
    while (q_busy.size() > 0 && q_busy[0].due <= cyc) begin
      b = q_busy.pop_front();
      n_vec++;
      if (b.due != cyc || ex_busy !== b.busy) begin
        n_err++;
        $display("FAIL %s: ex_busy got %b expected %b (cycle %0d, due %0d)",
                 b.tag, ex_busy, b.busy, cyc, b.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_out(input string tag, input logic rw, input logic mr, input logic mw,
                          input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] d,
                          input logic [31:0] npc, input logic [4:0] rd);
    exp_t e;
    e.due = cyc + 1; e.tag = tag; e.rw = rw; e.mr = mr; e.mw = mw; e.wb = wb;
    e.alu = alu; e.d = d; e.npc = npc; e.rd = rd;
    q_out.push_back(e);
    last_exp = e;
  endtask

  task automatic push_bubble(input string tag);
    push_out(tag, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic push_hold(input string tag);
    exp_t e;
    e = last_exp;
    e.due = cyc + 1;
    e.tag = tag;
    q_out.push_back(e);
  endtask

  task automatic push_busy(input string tag, input logic v);
    bexp_t b;
    b.due = cyc; b.tag = tag; b.busy = v;
    q_busy.push_back(b);
  endtask

  task automatic drive(input logic [3:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] npc,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] wb);
    valid_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    ALUop = op; ALUSrc = src; A = a; B = b; Imm = imm; NPC2 = npc; rd2 = rd;
    RegWrite_ID = rw; memR_ID = mr; memW_ID = mw; WBdata_ID = wb;
  endtask

  // exp_rw is the hand-derived RegWrite_EX (0 when rd2 is r0).
  task automatic issue(input string tag, input logic [3:0] op, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] npc, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [1:0] wb,
                       input logic exp_rw, input logic [31:0] exp_alu);
    drive(op, src, a, b, imm, npc, rd, rw, mr, mw, wb);
    push_out(tag, exp_rw, mr, mw, wb, exp_alu, b, npc, rd);
    push_busy(tag, 1'b0);
    step();
  endtask

`ifdef EX_STAGE_MUL_EN
  task automatic mul_run(input string tag, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] prod,
                         input int stall_at, input int stall_len);
    drive(ALU_MUL, src, a, b, imm, 32'h2000, 5'd5, 1'b1, 1'b0, 1'b0, WB_ALU);
    for (int k = 0; k < 32 + stall_len; k++) begin
      stall_in = (k >= stall_at) && (k < stall_at + stall_len);
      push_busy({tag, "_busy"}, 1'b1);
      push_bubble({tag, "_bubble"});
      step();
    end
    stall_in = 1'b0;
    push_busy({tag, "_done_busy"}, 1'b0);
    push_out({tag, "_result"}, 1'b1, 1'b0, 1'b0, WB_ALU, prod, b, 32'h2000, 5'd5);
    step();
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b1;
    drive(ALU_ADD, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, WB_ALU);
    valid_in = 1'b0;
    step();
    push_bubble("reset_state");
    push_busy("reset_busy", 1'b0);
    step();
    reset = 1'b0;

    issue("add_imm",  ALU_ADD,  1, 32'd5, 32'h55, 32'd7, 32'h1004, 5'd3, 1, 0, 0, WB_ALU, 1, 32'd12);
    issue("sub",      ALU_SUB,  0, 32'd10, 32'd3, 32'd0, 32'h1008, 5'd6, 1, 0, 0, WB_ALU, 1, 32'd7);
    issue("sub_wrap", ALU_SUB,  0, 32'd0, 32'd1, 32'd0, 32'h100c, 5'd6, 1, 0, 0, WB_ALU, 1, 32'hFFFF_FFFF);
    issue("and",      ALU_AND,  0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h1010, 5'd8, 1, 0, 0, WB_ALU, 1, 32'hF000_F000);
    issue("or",       ALU_OR,   0, 32'hF0F0_F0F0, 32'h0F00_000F, 0, 32'h1014, 5'd8, 1, 0, 0, WB_ALU, 1, 32'hFFF0_F0FF);
    issue("xor",      ALU_XOR,  0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 32'h1018, 5'd8, 1, 0, 0, WB_ALU, 1, 32'hF0F0_0F0F);
    issue("sll31",    ALU_SLL,  0, 32'd1, 32'd31, 0, 32'h101c, 5'd9, 1, 0, 0, WB_ALU, 1, 32'h8000_0000);
    issue("sll_amt",  ALU_SLL,  0, 32'd1, 32'h21, 0, 32'h1020, 5'd9, 1, 0, 0, WB_ALU, 1, 32'd2);
    issue("srl",      ALU_SRL,  0, 32'h8000_0000, 32'd4, 0, 32'h1024, 5'd9, 1, 0, 0, WB_ALU, 1, 32'h0800_0000);
    issue("sra",      ALU_SRA,  0, 32'h8000_0000, 32'd4, 0, 32'h1028, 5'd9, 1, 0, 0, WB_ALU, 1, 32'hF800_0000);
    issue("slt_neg",  ALU_SLT,  0, 32'hFFFF_FFFF, 32'd1, 0, 32'h102c, 5'd4, 1, 0, 0, WB_ALU, 1, 32'd1);
    issue("sltu_big", ALU_SLTU, 0, 32'hFFFF_FFFF, 32'd1, 0, 32'h1030, 5'd4, 1, 0, 0, WB_ALU, 1, 32'd0);
    issue("slt_pos",  ALU_SLT,  0, 32'd1, 32'hFFFF_FFFF, 0, 32'h1034, 5'd4, 1, 0, 0, WB_ALU, 1, 32'd0);
    issue("sltu_sml", ALU_SLTU, 0, 32'd1, 32'hFFFF_FFFF, 0, 32'h1038, 5'd4, 1, 0, 0, WB_ALU, 1, 32'd1);
    issue("passb",    ALU_PASSB, 1, 32'h99, 32'h77, 32'h1234, 32'h103c, 5'd31, 1, 0, 0, WB_NPC, 1, 32'h1234);
    issue("store",    ALU_ADD,  1, 32'h100, 32'hDEAD_BEEF, 32'd8, 32'h1040, 5'd0, 0, 0, 1, WB_ALU, 0, 32'h108);
    issue("load",     ALU_ADD,  1, 32'h200, 32'h5, 32'hFFFF_FFFC, 32'h1044, 5'd7, 1, 1, 0, WB_MEM, 1, 32'h1FC);
    issue("rd0",      ALU_ADD,  0, 32'd2, 32'd3, 0, 32'h1048, 5'd0, 1, 0, 0, WB_ALU, 0, 32'd5);
    issue("undef",    4'd15,    0, 32'd2, 32'd3, 0, 32'h104c, 5'd2, 1, 0, 0, WB_ALU, 1, 32'd0);

    drive(ALU_ADD, 0, 32'd2, 32'd3, 0, 32'h1050, 5'd2, 1, 0, 0, WB_ALU);
    valid_in = 1'b0;
    push_bubble("invalid_slot");
    push_busy("invalid_busy", 1'b0);
    step();

    issue("pre_stall", ALU_ADD, 0, 32'd1, 32'd2, 0, 32'h1054, 5'd10, 1, 0, 0, WB_ALU, 1, 32'd3);
    for (int k = 0; k < 2; k++) begin
      drive(ALU_XOR, 0, 32'hAAAA, 32'h5555, 0, 32'h1058, 5'd11, 1, 1, 1, WB_MEM);
      stall_in = 1'b1;
      push_hold("stall_hold");
      push_busy("stall_busy", 1'b0);
      step();
    end
    issue("post_stall", ALU_XOR, 0, 32'hAAAA, 32'h5555, 0, 32'h1058, 5'd11, 1, 0, 0, WB_ALU, 1, 32'hFFFF);

    drive(ALU_ADD, 0, 32'd4, 32'd4, 0, 32'h105c, 5'd12, 1, 0, 0, WB_ALU);
    flush_in = 1'b1;
    push_bubble("flush");
    push_busy("flush_busy", 1'b0);
    step();
    drive(ALU_ADD, 0, 32'd4, 32'd4, 0, 32'h1060, 5'd12, 1, 0, 0, WB_ALU);
    flush_in = 1'b1;
    stall_in = 1'b1;
    push_bubble("flush_over_stall");
    push_busy("flush_stall_busy", 1'b0);
    step();

`ifdef EX_STAGE_MUL_EN
    mul_run("mul", 0, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);
    issue("after_mul", ALU_ADD, 0, 32'd6, 32'd7, 0, 32'h2004, 5'd5, 1, 0, 0, WB_ALU, 1, 32'd13);
    mul_run("mul_stall", 0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 3);
    mul_run("mul_trunc", 1, 32'h1234_5678, 32'hAA, 32'h10, 32'h2345_6780, 0, 0);

    drive(ALU_MUL, 0, 32'd6, 32'd7, 0, 32'h2000, 5'd5, 1, 0, 0, WB_ALU);
    for (int k = 0; k < 9; k++) begin
      push_busy("mulf_busy", 1'b1);
      push_bubble("mulf_bubble");
      step();
    end
    flush_in = 1'b1;
    push_busy("mulf_flush_busy", 1'b0);
    push_bubble("mulf_flush");
    step();
    issue("rd0_after_flush", ALU_ADD, 1, 32'd5, 32'd0, 32'd7, 32'h2008, 5'd0, 1, 0, 0, WB_ALU, 0, 32'd12);

    drive(ALU_MUL, 0, 32'd6, 32'd7, 0, 32'h2000, 5'd5, 1, 0, 0, WB_ALU);
    for (int k = 0; k < 10; k++) begin
      push_busy("mulr_busy", 1'b1);
      push_bubble("mulr_bubble");
      step();
    end
    reset = 1'b1;
    push_busy("mulr_reset_busy", 1'b0);
    push_bubble("mulr_reset");
    step();
    reset = 1'b0;
    issue("after_reset", ALU_ADD, 0, 32'd20, 32'd22, 0, 32'h200c, 5'd6, 1, 0, 0, WB_ALU, 1, 32'd42);
`else
    issue("mul_undef", ALU_MUL, 0, 32'd6, 32'd7, 0, 32'h2000, 5'd5, 1, 0, 0, WB_ALU, 1, 32'd0);
    issue("after_mul", ALU_ADD, 0, 32'd6, 32'd7, 0, 32'h2004, 5'd5, 1, 0, 0, WB_ALU, 1, 32'd13);
`endif

    valid_in = 1'b0;
    for (int i = 0; i < 5 && (q_out.size() > 0 || q_busy.size() > 0); i++) step();
    if (q_out.size() > 0 || q_busy.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d output and %0d busy checks still pending, expected 0",
               q_out.size(), q_busy.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
